// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core front end: reset vector, the
// canonical nop encoding and the instruction-fetch state encoding.
package npc_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,   // request outstanding, not yet accepted
        IFU_WAIT = 2'd1,   // request accepted, awaiting response
        IFU_HOLD = 2'd2    // fetched instruction presented downstream
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, keeps exactly one imem read in
// flight and presents the fetched word with its PC until the decoder
// retires it. Redirects arriving while a read is committed are parked and
// the in-flight response is discarded when it returns.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    ifu_state_e  r_state;
    ifu_state_e  w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_inst;
    logic [31:0] w_inst_next;
    logic        r_inst_valid;
    logic        w_inst_valid_next;
    logic        r_kill;
    logic        w_kill_next;
    logic [31:0] r_target;
    logic [31:0] w_target_next;
    logic        r_req_valid;
    logic        w_req_valid_next;

    // Redirect targets are always word aligned; the low bits are discarded.
    logic [31:0] w_redirect_target;
    logic        w_req_fire;

    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_req_fire        = r_req_valid & imem_req_ready;

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_inst;
    assign pc             = r_pc;

    // State register and all registered outputs; reset returns everything to the boot vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IFU_REQ;
            r_fetch_pc   <= RESET_PC;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_kill       <= 1'b0;
            r_target     <= RESET_PC;
            r_req_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_pc   <= w_fetch_pc_next;
            r_pc         <= w_pc_next;
            r_inst       <= w_inst_next;
            r_inst_valid <= w_inst_valid_next;
            r_kill       <= w_kill_next;
            r_target     <= w_target_next;
            r_req_valid  <= w_req_valid_next;
        end
    end

    // Next-state and next-PC selection for the fetch loop.
    always_comb begin
        w_state_next      = r_state;
        w_fetch_pc_next   = r_fetch_pc;
        w_pc_next         = r_pc;
        w_inst_next       = r_inst;
        w_inst_valid_next = r_inst_valid;
        w_kill_next       = r_kill;
        w_target_next     = r_target;

        case (r_state)
            IFU_REQ: begin
                // The address is already committed on the bus, so a redirect
                // here can only poison the response that will come back.
                if (redirect_valid) begin
                    w_kill_next   = 1'b1;
                    w_target_next = w_redirect_target;
                end
                if (w_req_fire) begin
                    w_state_next = IFU_WAIT;
                end
            end

            IFU_WAIT: begin
                if (imem_rsp_valid) begin
                    if (r_kill || redirect_valid) begin
                        // Stale data: drop it and refetch from the newest target.
                        w_kill_next     = 1'b0;
                        w_fetch_pc_next = redirect_valid ? w_redirect_target : r_target;
                        w_state_next    = IFU_REQ;
                    end else begin
                        w_inst_next       = imem_rsp_data;
                        w_pc_next         = r_fetch_pc;
                        w_inst_valid_next = 1'b1;
                        w_state_next      = IFU_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_kill_next   = 1'b1;
                    w_target_next = w_redirect_target;
                end
            end

            IFU_HOLD: begin
                if (inst_ready) begin
                    w_fetch_pc_next   = redirect_valid ? w_redirect_target : r_pc + 32'd4;
                    w_inst_valid_next = 1'b0;
                    w_state_next      = IFU_REQ;
                end
            end

            default: begin
                w_state_next = IFU_REQ;
            end
        endcase
    end

    // The request strobe is registered so it tracks the state it will be seen in.
    always_comb begin
        w_req_valid_next = (w_state_next == IFU_REQ);
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios followed by a
// randomized run, checked against a transaction-level PC model and an
// address-derived instruction memory.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .pc             (pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs applied on every step
    logic        cfg_ready, cfg_iready, cfg_rv, cfg_spurious;
    logic [31:0] cfg_rpc;
    int          cfg_delay;

    // Memory responder state
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    // Reference model: the PC the next presented instruction must carry
    logic [31:0] exp_pc;
    int          idle;
    logic [31:0] acc_q[$];
    logic [31:0] ret_q[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc = RST_PC;
        idle   = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, run the responder
    // and advance the model for the upcoming rising edge.
    task automatic step();
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(pend_addr);
                pend           = 1'b0;
            end else begin
                pend_cnt--;
            end
        end else if (cfg_spurious) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        imem_req_ready = cfg_ready;
        inst_ready     = cfg_iready;
        redirect_valid = cfg_rv;
        redirect_pc    = cfg_rpc;
        if (rst_n) begin
            if (imem_req_valid && cfg_ready) begin
                chk("req_addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                pend_cnt  = cfg_delay - 1;
                acc_q.push_back(imem_req_addr);
            end
            if (inst_valid) begin
                idle = 0;
                chk("pres_pc", pc, exp_pc);
                chk("pres_inst", inst, memf(exp_pc));
                if (cfg_iready) begin
                    ret_q.push_back(pc);
                    exp_pc = cfg_rv ? (cfg_rpc & 32'hFFFF_FFFC) : exp_pc + 32'd4;
                end
            end else begin
                idle++;
                if (cfg_rv) exp_pc = cfg_rpc & 32'hFFFF_FFFC;
                if (idle > 100) begin
                    chk("fetch_timeout", idle, 0);
                    idle = 0;
                end
            end
        end
    endtask

    task automatic run_until_hold(input string tag);
        int n = 0;
        step();
        while (!inst_valid && n < 100) begin
            step();
            n++;
        end
        chk(tag, {31'd0, inst_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] hold_pc, hold_inst;
        int          nvalid;
        int          base;

        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        cfg_ready = 1'b1; cfg_iready = 1'b1; cfg_rv = 1'b0; cfg_rpc = 32'd0;
        cfg_delay = 1; cfg_spurious = 1'b0;
        pend = 1'b0; pend_cnt = 0; pend_addr = 32'd0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_pc", pc, RST_PC);
        chk("rst_addr", imem_req_addr, RST_PC);
        rst_n = 1'b1;

        // Memory not ready for 5 cycles: request held
        cfg_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_req_addr, RST_PC);
        end
        chk("stall_no_accept", acc_q.size(), 0);

        // Best-case loop: three instructions in nine cycles
        cfg_ready = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (inst_valid) nvalid++;
        end
        chk("loop_valid_cycles", nvalid, 3);
        chk("loop_ret_count", ret_q.size(), 3);
        chk("loop_acc_count", acc_q.size(), 3);
        if (ret_q.size() >= 3) begin
            chk("loop_pc0", ret_q[0], 32'h8000_0000);
            chk("loop_pc1", ret_q[1], 32'h8000_0004);
            chk("loop_pc2", ret_q[2], 32'h8000_0008);
        end

        // Held instruction stays stable, then retire with misaligned redirect
        cfg_iready = 1'b0;
        run_until_hold("hold_reached");
        chk("hold_pc", pc, 32'h8000_000C);
        hold_pc = pc;
        hold_inst = inst;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_pc_stable", pc, hold_pc);
            chk("hold_inst_stable", inst, hold_inst);
        end
        cfg_iready = 1'b1; cfg_rv = 1'b1; cfg_rpc = 32'h8000_0103; cfg_delay = 3;
        step();
        cfg_rv = 1'b0;
        step();
        chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("redir_addr", imem_req_addr, 32'h8000_0100);

        // Redirect while the response is in flight
        base = acc_q.size();
        cfg_rv = 1'b1; cfg_rpc = 32'h8000_0200;
        step();
        chk("wait_req_low", {31'd0, imem_req_valid}, 32'd0);
        chk("wait_inst_low", {31'd0, inst_valid}, 32'd0);
        cfg_rv = 1'b0; cfg_iready = 1'b0; cfg_delay = 1;
        run_until_hold("kill_hold_reached");
        chk("kill_pc", pc, 32'h8000_0200);
        chk("kill_inst", inst, memf(32'h8000_0200));
        chk("kill_acc_count", acc_q.size() - base + 1, 2);
        if (acc_q.size() >= base + 1 && base >= 1) begin
            chk("kill_acc0", acc_q[base-1], 32'h8000_0100);
            chk("kill_acc1", acc_q[base], 32'h8000_0200);
        end

        // PC wraps from the top of the address space
        cfg_iready = 1'b1; cfg_rv = 1'b1; cfg_rpc = 32'hFFFF_FFFC;
        step();
        cfg_rv = 1'b0; cfg_iready = 1'b0;
        run_until_hold("wrap_hold_reached");
        chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
        cfg_iready = 1'b1;
        step();
        step();
        chk("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);
        cfg_iready = 1'b0;
        run_until_hold("wrap0_hold_reached");
        chk("wrap0_pc", pc, 32'h0000_0000);

        // Asynchronous reset while waiting on a response
        cfg_iready = 1'b1; cfg_delay = 3;
        step();
        step();
        step();
        chk("pre_rst_wait", {31'd0, imem_req_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_inst", inst, NOP);
        chk("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("arst_pc", pc, RST_PC);
        chk("arst_addr", imem_req_addr, RST_PC);
        model_reset();
        cfg_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cfg_spurious = 1'b1;
        step();
        cfg_spurious = 1'b0;
        chk("late_rsp_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("late_rsp_addr", imem_req_addr, RST_PC);
        cfg_ready = 1'b1; cfg_iready = 1'b0; cfg_delay = 1;
        run_until_hold("restart_hold_reached");
        chk("restart_pc", pc, RST_PC);
        chk("restart_inst", inst, memf(RST_PC));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cfg_ready    = ($urandom_range(0, 3) != 0);
            cfg_iready   = ($urandom_range(0, 4) < 3);
            cfg_rv       = ($urandom_range(0, 9) == 0);
            cfg_rpc      = $urandom;
            cfg_delay    = $urandom_range(1, 3);
            cfg_spurious = ($urandom_range(0, 7) == 0);
            step();
        end
        cfg_rv = 1'b0; cfg_spurious = 1'b0; cfg_ready = 1'b1; cfg_iready = 1'b0;
        run_until_hold("final_hold_reached");
        chk("final_pc", pc, exp_pc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
